// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_ctrl_pkg;

    localparam int SERIAL_ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sa_state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell built from two half adders; purely combinational.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.x(a),  .y(b),  .s(s1), .c(c1));
    half_adder u_ha1 (.x(s1), .y(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell; result valid WIDTH cycles after accept.
// Result is held in HOLD until consumed; no new operands are taken until the result leaves.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // in_ready is forced low while reset is asserted, high from the first cycle after release
    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && (state == IDLE);
    assign last      = (state == RUN) && (cnt == CNT_LAST);

    always_comb begin
        r_nxt            = r_sh >> 1;
        r_nxt[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= r_nxt;
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
            // the last bit goes straight into the result, bypassing r_sh
            if (last) begin
                sum  <= r_nxt;
                cout <= fa_co;
            end
        end
    end

endmodule
